zx_video_scan: RTL and testbench
================================

// Module: zx_video_scan
// PURPOSE
//  ZX Spectrum 48K video scanner: the read-side consumer of the dual-port video RAM.
//  Generates raster counters, bitmap/attribute fetch addresses and read strobes on the
//  VRAM read port, and produces border, flash and bright-resolved RGBI pixels.
//  Also generates sync, blank and the frame interrupt for the CPU side.
// PARAMETERS
//  AW        13   VRAM address width; matches the read-port address width
//  HCOUNT   448   pixel clocks per line (hc 0..HCOUNT-1)
//  VCOUNT   312   lines per frame (vc 0..VCOUNT-1)
//  HS_START 344 / HS_END 375   hsync asserted for hc in [HS_START,HS_END]
//  VS_START 248 / VS_END 251   vsync asserted for vc in [VS_START,VS_END]
//  HB_START 320 / HB_END 415   hblank for hc in [HB_START,HB_END]
//  VB_START 240 / VB_END 255   vblank for vc in [VB_START,VB_END]
//  INT_LINE 248 / INT_LEN 64   irq asserted on vc==INT_LINE for hc in [0,INT_LEN-1]
// PORTS
//  clock   in   1   system clock
//  reset   in   1   synchronous reset, active-high
//  ce      in   1   pixel clock enable; all state advances only on clock edges with ce=1
//  border  in   3   border colour {g,r,b}
//  vce     out  1   VRAM read enable (drives read-port ce2)
//  va      out  AW  VRAM read address (drives read-port a2)
//  vd      in   8   VRAM read data; registered by the RAM on the edge where vce=1
//  rgbi    out  4   {bright,g,r,b}; forced 0 while blanking
//  hsync   out  1   active-high
//  vsync   out  1   active-high
//  blank   out  1   hblank | vblank
//  irq     out  1   active-high frame interrupt
// BEHAVIOUR
//  Reset: hc=0, vc=0, flash counter fc=0, shift=0, attr=0; all outputs 0. Reset wins over ce.
//  Counters: on ce, hc increments and wraps HCOUNT-1 -> 0. On that wrap vc increments and wraps
//   VCOUNT-1 -> 0. On the vc wrap, 5-bit fc increments and wraps 31 -> 0. Flash phase is fc[4].
//  Active area: hc in [8,263] and vc in [0,191]. Pixel x=hc-8, y=vc. Column n=0..31 occupies
//   hc 8n+8..8n+15.
//  Fetch for column n happens on line vc<192, during hc 8n+4..8n+7:
//   - hc[2:0]==4: vce=ce, va = bitmap addr {y[7:6],y[2:0],y[5:3],n[4:0]}
//   - hc[2:0]==5: vce=ce, va = attr addr {3'b110,y[7:3],n[4:0]}; capture vd as bitmap byte
//   - hc[2:0]==6: capture vd as attribute byte
//   - hc[2:0]==7: load shift<=bitmap, attr_cur<=attribute
//   vce/va decode combinationally from registered hc/vc and ce. Otherwise vce=0 and va=0.
//   Correct with ce every clock: the RAM read is registered, so data is valid on the next edge.
//  Pixel: on each ce edge with hc in [8,263] (before increment), shift<<=1 and output bit
//   p=shift[7]. Flash inverts when attr[7]&fc[4]: p^=1.
//   - p=1 -> rgbi={attr[6],attr[2:0]} (ink)
//   - p=0 -> rgbi={attr[6],attr[5:3]} (paper)
//   After the ce edge at hc=h, rgbi shows pixel h-8. Latency is fixed and identical for border.
//  Border: outside the active area, rgbi={1'b0,border}. border is sampled on every ce edge.
//   A mid-line change takes effect on the next pixel.
//  hsync, vsync, blank and irq are registered from the counters on ce edges, aligned with
//   rgbi (same one-edge latency). blank forces rgbi=0. Blank overrides border and active pixels.
//  ce=0: every register holds its value; vce=0.
//  Mid-frame reset restarts at hc=vc=0 with no partial fetch. The first line after reset
//   displays correctly, since column 0 is fetched at hc 4..7.
// STRUCTURE
//  Package zx_video_pkg holds:
//   - timing constants (the parameter defaults);
//   - attribute field positions (FLASH=7, BRIGHT=6, PAPER=5:3, INK=2:0);
//   - functions bitmap_addr(y,n) and attr_addr(y,n).
//  One sub-module, zx_video_counters: hc, vc, fc plus line/frame wrap strobes.
//  Fetch, shift and colour logic stay in this module.
// TESTING
//  1 reset mid-frame, ce=1 -> hc=vc=0, outputs 0. The next frame starts with vce at hc=4, va=0x0000.
//  2 Address map:
//    y=1 n=0 -> 0x0100; y=8 n=0 -> 0x0020; y=64 n=0 -> 0x0800;
//    y=191 n=31 -> bitmap 0x17FF, attr 0x1AFF.
//  3 VRAM model, col 0 bitmap 0x80, attr 0x47 -> after edge hc=8 rgbi=4'b1111,
//    then edges hc=9..15 -> 4'b1000.
//  4 attr 0x87, bitmap 0x80: fc[4]=0 -> pixel0 ink 0111; fc[4]=1 -> pixel0 paper 0000,
//    pixels1-7 ink 0111.
//  5 border=3'b010, vc=200 -> rgbi=0010 outside blank. hc=320..415 -> rgbi=0, blank=1.
//  6 Full frame, ce every 2nd clock:
//    - irq high for exactly 64 ce at vc=248;
//    - hsync 32 ce per line;
//    - vsync 4 lines;
//    - vce count = 192*64 per frame.

Source files
------------

// File: rtl/zx_video_pkg.sv
// ---------------------------------------------------------------------------
// zx_video_pkg
// Shared definitions for the ZX Spectrum 48K video scanner:
//   - default raster timing (pixel clocks per line, lines per frame,
//     sync / blank / interrupt windows);
//   - fixed geometry of the 256x192 display area and its fetch window;
//   - attribute byte field positions;
//   - bitmap_addr / attr_addr: VRAM address of a character cell's bitmap
//     byte and attribute byte.
// ---------------------------------------------------------------------------
package zx_video_pkg;

    localparam int AW_DEF       = 13;
    localparam int HCOUNT_DEF   = 448;
    localparam int VCOUNT_DEF   = 312;
    localparam int HS_START_DEF = 344;
    localparam int HS_END_DEF   = 375;
    localparam int VS_START_DEF = 248;
    localparam int VS_END_DEF   = 251;
    localparam int HB_START_DEF = 320;
    localparam int HB_END_DEF   = 415;
    localparam int VB_START_DEF = 240;
    localparam int VB_END_DEF   = 255;
    localparam int INT_LINE_DEF = 248;
    localparam int INT_LEN_DEF  = 64;

    // Raster counter width; covers HCOUNT and VCOUNT up to 512.
    localparam int CNT_W = 9;

    // Display area: hc 8..263 on lines 0..191; fetches run four clocks
    // ahead of display, so the fetch window ends at hc 255.
    localparam int ACT_H_FIRST  = 8;
    localparam int ACT_H_LAST   = 263;
    localparam int ACT_LINES    = 192;
    localparam int FETCH_H_LAST = 255;

    // Position of hc[2:0] within an 8-clock character cell.
    localparam logic [2:0] PH_BMP_RD  = 3'd4;
    localparam logic [2:0] PH_ATTR_RD = 3'd5;
    localparam logic [2:0] PH_ATTR_CP = 3'd6;
    localparam logic [2:0] PH_LOAD    = 3'd7;

    // Attribute byte fields.
    localparam int ATTR_FLASH     = 7;
    localparam int ATTR_BRIGHT    = 6;
    localparam int ATTR_PAPER_MSB = 5;
    localparam int ATTR_PAPER_LSB = 3;
    localparam int ATTR_INK_MSB   = 2;
    localparam int ATTR_INK_LSB   = 0;

    // Bitmap rows are interleaved: third of screen, pixel row, character row.
    function automatic logic [12:0] bitmap_addr(input logic [7:0] y, input logic [4:0] n);
        return {y[7:6], y[2:0], y[5:3], n};
    endfunction

    // Attributes are a linear 32x24 array starting at 0x1800.
    function automatic logic [12:0] attr_addr(input logic [7:0] y, input logic [4:0] n);
        return {3'b110, y[7:3], n};
    endfunction

endpackage

// File: rtl/zx_video_counters.sv
// ---------------------------------------------------------------------------
// zx_video_counters
// Raster position counters for the video scanner. hc counts pixel clocks
// within a line, vc counts lines within a frame, and a 5-bit frame counter
// provides the flash phase (its MSB toggles every 16 frames).
// Ports:
//   clock_i   system clock
//   reset_i   synchronous active-high reset (clears all counters)
//   ce_i      pixel clock enable; counters advance only when high
//   hc_o      horizontal position 0..HCOUNT-1
//   vc_o      line number 0..VCOUNT-1
//   flash_o   flash phase
// ---------------------------------------------------------------------------
module zx_video_counters
    import zx_video_pkg::*;
#(
    parameter int HCOUNT = HCOUNT_DEF,
    parameter int VCOUNT = VCOUNT_DEF
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             ce_i,
    output logic [CNT_W-1:0] hc_o,
    output logic [CNT_W-1:0] vc_o,
    output logic             flash_o
);

    logic [CNT_W-1:0] hc_q, hc_d;
    logic [CNT_W-1:0] vc_q, vc_d;
    logic [4:0]       fc_q, fc_d;
    logic             line_end;
    logic             frame_end;

    // Wrap strobes: this ce edge closes the current line / frame.
    assign line_end  = (hc_q == CNT_W'(HCOUNT - 1));
    assign frame_end = line_end && (vc_q == CNT_W'(VCOUNT - 1));

    always_comb begin
        hc_d = hc_q;
        vc_d = vc_q;
        fc_d = fc_q;
        if (ce_i) begin
            hc_d = line_end ? '0 : hc_q + 1'b1;
            if (line_end) begin
                vc_d = frame_end ? '0 : vc_q + 1'b1;
            end
            if (frame_end) begin
                fc_d = fc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            hc_q <= '0;
            vc_q <= '0;
            fc_q <= '0;
        end else begin
            hc_q <= hc_d;
            vc_q <= vc_d;
            fc_q <= fc_d;
        end
    end

    assign hc_o    = hc_q;
    assign vc_o    = vc_q;
    assign flash_o = fc_q[4];

endmodule

// File: rtl/zx_video_scan.sv
// ---------------------------------------------------------------------------
// zx_video_scan
// ZX Spectrum 48K video scanner: read side of the dual-port video RAM.
// Fetches bitmap and attribute bytes ahead of the beam, serialises pixels,
// resolves ink/paper/bright/flash and border colour, and produces sync,
// blank and the frame interrupt. All registered outputs share the same
// one-edge latency from the raster counters.
// Ports:
//   clock   system clock
//   reset   synchronous active-high reset
//   ce      pixel clock enable
//   border  border colour {g,r,b}
//   vce     VRAM read enable
//   va      VRAM read address
//   vd      VRAM read data (registered in the RAM on edges with vce=1)
//   rgbi    {bright,g,r,b}, zero while blanking
//   hsync / vsync / blank / irq   active-high timing outputs
// ---------------------------------------------------------------------------
module zx_video_scan
    import zx_video_pkg::*;
#(
    parameter int AW       = AW_DEF,
    parameter int HCOUNT   = HCOUNT_DEF,
    parameter int VCOUNT   = VCOUNT_DEF,
    parameter int HS_START = HS_START_DEF,
    parameter int HS_END   = HS_END_DEF,
    parameter int VS_START = VS_START_DEF,
    parameter int VS_END   = VS_END_DEF,
    parameter int HB_START = HB_START_DEF,
    parameter int HB_END   = HB_END_DEF,
    parameter int VB_START = VB_START_DEF,
    parameter int VB_END   = VB_END_DEF,
    parameter int INT_LINE = INT_LINE_DEF,
    parameter int INT_LEN  = INT_LEN_DEF
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          ce,
    input  logic [2:0]    border,
    output logic          vce,
    output logic [AW-1:0] va,
    input  logic [7:0]    vd,
    output logic [3:0]    rgbi,
    output logic          hsync,
    output logic          vsync,
    output logic          blank,
    output logic          irq
);

    logic [CNT_W-1:0] hc, vc;
    logic             flash_phase;

    zx_video_counters #(
        .HCOUNT (HCOUNT),
        .VCOUNT (VCOUNT)
    ) u_counters (
        .clock_i (clock),
        .reset_i (reset),
        .ce_i    (ce),
        .hc_o    (hc),
        .vc_o    (vc),
        .flash_o (flash_phase)
    );

    logic [7:0] bmp_q,    bmp_d;     // fetched bitmap byte
    logic [7:0] attr_f_q, attr_f_d;  // fetched attribute byte
    logic [7:0] shift_q,  shift_d;   // pixel shift register, MSB first
    logic [7:0] attr_q,   attr_d;    // attribute of the cell being displayed
    logic [3:0] rgbi_q,   rgbi_d;
    logic       hsync_q,  hsync_d;
    logic       vsync_q,  vsync_d;
    logic       blank_q,  blank_d;
    logic       irq_q,    irq_d;

    logic       fetch_win, active, hb, vb, pix;
    logic [7:0] y;
    logic [4:0] col;
    logic [2:0] ph;

    assign y   = vc[7:0];
    assign col = hc[7:3];
    assign ph  = hc[2:0];

    assign fetch_win = (vc < CNT_W'(ACT_LINES)) && (hc <= CNT_W'(FETCH_H_LAST));
    assign active    = (vc < CNT_W'(ACT_LINES)) && (hc >= CNT_W'(ACT_H_FIRST))
                       && (hc <= CNT_W'(ACT_H_LAST));
    assign hb        = (hc >= CNT_W'(HB_START)) && (hc <= CNT_W'(HB_END));
    assign vb        = (vc >= CNT_W'(VB_START)) && (vc <= CNT_W'(VB_END));
    assign pix       = shift_q[7] ^ (attr_q[ATTR_FLASH] & flash_phase);

    // Read strobes are gated by reset so a reset cycle never issues a fetch.
    always_comb begin
        vce = 1'b0;
        va  = '0;
        if (!reset && fetch_win) begin
            if (ph == PH_BMP_RD) begin
                vce = ce;
                va  = AW'(bitmap_addr(y, col));
            end else if (ph == PH_ATTR_RD) begin
                vce = ce;
                va  = AW'(attr_addr(y, col));
            end
        end
    end

    always_comb begin
        bmp_d    = bmp_q;
        attr_f_d = attr_f_q;
        shift_d  = shift_q;
        attr_d   = attr_q;
        rgbi_d   = rgbi_q;
        hsync_d  = hsync_q;
        vsync_d  = vsync_q;
        blank_d  = blank_q;
        irq_d    = irq_q;
        if (ce) begin
            if (active) begin
                shift_d = shift_q << 1;
            end
            // A load on the last pixel of a cell takes priority over the shift;
            // that pixel has already been taken from the old shift_q above.
            if (fetch_win) begin
                case (ph)
                    PH_ATTR_RD: bmp_d    = vd;
                    PH_ATTR_CP: attr_f_d = vd;
                    PH_LOAD: begin
                        shift_d = bmp_q;
                        attr_d  = attr_f_q;
                    end
                    default: ;
                endcase
            end
            hsync_d = (hc >= CNT_W'(HS_START)) && (hc <= CNT_W'(HS_END));
            vsync_d = (vc >= CNT_W'(VS_START)) && (vc <= CNT_W'(VS_END));
            blank_d = hb | vb;
            irq_d   = (vc == CNT_W'(INT_LINE)) && (hc < CNT_W'(INT_LEN));
            if (hb | vb) begin
                rgbi_d = 4'b0000;
            end else if (active) begin
                rgbi_d = pix ? {attr_q[ATTR_BRIGHT], attr_q[ATTR_INK_MSB:ATTR_INK_LSB]}
                             : {attr_q[ATTR_BRIGHT], attr_q[ATTR_PAPER_MSB:ATTR_PAPER_LSB]};
            end else begin
                rgbi_d = {1'b0, border};
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            bmp_q    <= '0;
            attr_f_q <= '0;
            shift_q  <= '0;
            attr_q   <= '0;
            rgbi_q   <= '0;
            hsync_q  <= 1'b0;
            vsync_q  <= 1'b0;
            blank_q  <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            bmp_q    <= bmp_d;
            attr_f_q <= attr_f_d;
            shift_q  <= shift_d;
            attr_q   <= attr_d;
            rgbi_q   <= rgbi_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            blank_q  <= blank_d;
            irq_q    <= irq_d;
        end
    end

    assign rgbi  = rgbi_q;
    assign hsync = hsync_q;
    assign vsync = vsync_q;
    assign blank = blank_q;
    assign irq   = irq_q;

endmodule

// File: tb/tb_zx_video_scan.sv
// ---------------------------------------------------------------------------
// tb_zx_video_scan
// Two scanner instances share one clock and one VRAM image. Both use a
// shortened line (280 clocks) with the fixed 256-pixel display area.
//   dut_a: 6-line frame, so flash (16 frames) and whole-frame counts fit;
//          random ce, a mid-frame reset, then ce on every second clock.
//   dut_b: 200-line frame covering all 192 display rows, ce every clock.
// A reference model derives expected outputs from the number of ce edges
// since reset, the VRAM contents and the screen layout rules.
// ---------------------------------------------------------------------------
module tb_zx_video_scan;

    localparam int H     = 280;
    localparam int HB_S  = 268, HB_E = 275, HS_S = 270, HS_E = 273;
    localparam int VA    = 6;
    localparam int VBS_A = 4, VBE_A = 5, VSS_A = 4, VSE_A = 4, IL_A = 5;
    localparam int VB    = 200;
    localparam int VBS_B = 194, VBE_B = 197, VSS_B = 195, VSE_B = 196, IL_B = 196;
    localparam int ILEN  = 64;
    localparam int FRAME_A = H * VA;
    localparam int FRAME_B = H * VB;

    logic        clk = 1'b0;
    logic        rst_a = 1'b1, rst_b = 1'b1, ce_a = 1'b0, ce_b = 1'b0;
    logic [2:0]  border = 3'b000;
    logic        vce_a, vce_b, hs_a, hs_b, vs_a, vs_b, bl_a, bl_b, irq_a, irq_b;
    logic [12:0] va_a, va_b;
    logic [7:0]  vd_a = 8'h00, vd_b = 8'h00;
    logic [3:0]  rgbi_a, rgbi_b;
    logic [7:0]  vram [8192];

    int n_cmp = 0, n_bad = 0;
    int t_a = 0, t_b = 0;
    logic [7:0] exp_a = '0, exp_b = '0;
    logic cnt_on = 1'b0, rst_seen = 1'b0;
    int irq_n = 0, hs_n = 0, vs_n = 0, vce_n = 0;

    always #5 clk = ~clk;

    zx_video_scan #(
        .HCOUNT(H), .VCOUNT(VA), .HS_START(HS_S), .HS_END(HS_E),
        .VS_START(VSS_A), .VS_END(VSE_A), .HB_START(HB_S), .HB_END(HB_E),
        .VB_START(VBS_A), .VB_END(VBE_A), .INT_LINE(IL_A), .INT_LEN(ILEN)
    ) dut_a (
        .clock(clk), .reset(rst_a), .ce(ce_a), .border(border), .vce(vce_a),
        .va(va_a), .vd(vd_a), .rgbi(rgbi_a), .hsync(hs_a), .vsync(vs_a),
        .blank(bl_a), .irq(irq_a)
    );

    zx_video_scan #(
        .HCOUNT(H), .VCOUNT(VB), .HS_START(HS_S), .HS_END(HS_E),
        .VS_START(VSS_B), .VS_END(VSE_B), .HB_START(HB_S), .HB_END(HB_E),
        .VB_START(VBS_B), .VB_END(VBE_B), .INT_LINE(IL_B), .INT_LEN(ILEN)
    ) dut_b (
        .clock(clk), .reset(rst_b), .ce(ce_b), .border(border), .vce(vce_b),
        .va(va_b), .vd(vd_b), .rgbi(rgbi_b), .hsync(hs_b), .vsync(vs_b),
        .blank(bl_b), .irq(irq_b)
    );

    // Registered-read VRAM ports.
    always @(posedge clk) begin
        if (vce_a) vd_a <= vram[va_a];
        if (vce_b) vd_b <= vram[va_b];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (time %0t)", tag, got, want, $time);
        end
    endtask

    function automatic int bmp_ref(input int y, input int n);
        return (y / 64) * 2048 + (y % 8) * 256 + ((y / 8) % 8) * 32 + n;
    endfunction

    function automatic int attr_ref(input int y, input int n);
        return 6144 + (y / 8) * 32 + n;
    endfunction

    // {enable, address}: a cell's bytes are read 4 and 5 clocks into the
    // cell preceding its display slot.
    function automatic logic [13:0] fetch_ref(input int h, input int v);
        if (v < 192 && h < 256 && h % 8 == 4) return {1'b1, 13'(bmp_ref(v, h / 8))};
        if (v < 192 && h < 256 && h % 8 == 5) return {1'b1, 13'(attr_ref(v, h / 8))};
        return '0;
    endfunction

    // {irq, blank, vsync, hsync, rgbi} after the ce edge at position (h, v).
    function automatic logic [7:0] ref_out(input int h, input int v, input int f,
                                           input logic [2:0] brd, input int vbs, input int vbe,
                                           input int vss, input int vse, input int il);
        logic bl, hs, vs, iq, bitv;
        logic [3:0] px;
        logic [7:0] b, at;
        int x;
        bl = (h >= HB_S && h <= HB_E) || (v >= vbs && v <= vbe);
        hs = (h >= HS_S && h <= HS_E);
        vs = (v >= vss && v <= vse);
        iq = (v == il) && (h < ILEN);
        if (bl) begin
            px = 4'b0000;
        end else if (v < 192 && h >= 8 && h <= 263) begin
            x    = h - 8;
            b    = vram[bmp_ref(v, x / 8)];
            at   = vram[attr_ref(v, x / 8)];
            bitv = b[7 - x % 8];
            if (at[7] && f >= 16) bitv = !bitv;
            px = bitv ? {at[6], at[2:0]} : {at[6], at[5:3]};
        end else begin
            px = {1'b0, brd};
        end
        return {iq, bl, vs, hs, px};
    endfunction

    task automatic step(input logic ra, input logic ca, input logic rb, input logic cb,
                        input logic [2:0] brd);
        logic [13:0] fa, fb;
        int ha, vha, fra, hb, vhb;
        logic ea, eb;
        @(negedge clk);
        rst_a = ra; ce_a = ca; rst_b = rb; ce_b = cb; border = brd;
        #1;
        ha = t_a % H; vha = (t_a / H) % VA; fra = (t_a / FRAME_A) % 32;
        hb = t_b % H; vhb = (t_b / H) % VB;
        fa = fetch_ref(ha, vha);
        fb = fetch_ref(hb, vhb);
        chk("vce_a", vce_a, ca && !ra && fa[13]);
        chk("va_a", va_a, (!ra && fa[13]) ? fa[12:0] : 13'h0);
        chk("vce_b", vce_b, cb && !rb && fb[13]);
        chk("va_b", va_b, (!rb && fb[13]) ? fb[12:0] : 13'h0);
        if (cnt_on && t_a < FRAME_A && vce_a) vce_n++;
        if (rst_seen && ca && !ra && t_a == 4) begin
            chk("rst_vce_hc4", vce_a, 1);
            chk("rst_va_hc4", va_a, 13'h0000);
            rst_seen = 1'b0;
        end
        if (cb && !rb) begin
            if (vhb == 1 && hb == 4)    chk("amap_y1_n0", va_b, 13'h0100);
            if (vhb == 8 && hb == 4)    chk("amap_y8_n0", va_b, 13'h0020);
            if (vhb == 64 && hb == 4)   chk("amap_y64_n0", va_b, 13'h0800);
            if (vhb == 191 && hb == 252) chk("amap_bmp_last", va_b, 13'h17FF);
            if (vhb == 191 && hb == 253) chk("amap_attr_last", va_b, 13'h1AFF);
        end
        @(posedge clk);
        ea = 1'b0; eb = 1'b0;
        if (ra) begin
            t_a = 0; exp_a = '0;
        end else if (ca) begin
            exp_a = ref_out(ha, vha, fra, brd, VBS_A, VBE_A, VSS_A, VSE_A, IL_A);
            t_a++; ea = 1'b1;
        end
        if (rb) begin
            t_b = 0; exp_b = '0;
        end else if (cb) begin
            exp_b = ref_out(hb, vhb, 0, brd, VBS_B, VBE_B, VSS_B, VSE_B, IL_B);
            t_b++; eb = 1'b1;
        end
        #2;
        chk("rgbi_a", rgbi_a, exp_a[3:0]);
        chk("hsync_a", hs_a, exp_a[4]);
        chk("vsync_a", vs_a, exp_a[5]);
        chk("blank_a", bl_a, exp_a[6]);
        chk("irq_a", irq_a, exp_a[7]);
        chk("rgbi_b", rgbi_b, exp_b[3:0]);
        chk("hsync_b", hs_b, exp_b[4]);
        chk("vsync_b", vs_b, exp_b[5]);
        chk("blank_b", bl_b, exp_b[6]);
        chk("irq_b", irq_b, exp_b[7]);
        if (ea && vha == 0) begin
            if (ha == 8)              chk("col0_px0_ink", rgbi_a, 4'b1111);
            if (ha >= 9 && ha <= 15)  chk("col0_paper", rgbi_a, 4'b1000);
            if (ha == 16)             chk("flash_px0", rgbi_a, (fra >= 16) ? 4'b0000 : 4'b0111);
            if (ha >= 17 && ha <= 23) chk("flash_px17", rgbi_a, (fra >= 16) ? 4'b0111 : 4'b0000);
        end
        if (ea && cnt_on) begin
            irq_n += int'(irq_a);
            hs_n  += int'(hs_a);
            vs_n  += int'(vs_a);
        end
        if (eb && vhb == 199 && hb == 100) chk("border_b", rgbi_b, {1'b0, brd});
        if (eb && hb == 270) chk("hblank_b", {bl_b, rgbi_b}, 5'h10);
    endtask

    initial begin
        int phase, iter, target;
        logic [2:0] brd;
        logic tgl;
        for (int i = 0; i < 8192; i++) vram[i] = 8'($urandom);
        vram[13'h0000] = 8'h80; vram[13'h1800] = 8'h47;
        vram[13'h0001] = 8'h80; vram[13'h1801] = 8'h87;

        repeat (3) step(1'b1, 1'b1, 1'b1, 1'b1, 3'b000);
        chk("rst_rgbi_a", rgbi_a, 0);
        chk("rst_sync_a", {irq_a, bl_a, vs_a, hs_a}, 0);
        chk("rst_vce_a", vce_a, 0);
        chk("rst_rgbi_b", rgbi_b, 0);
        chk("rst_sync_b", {irq_b, bl_b, vs_b, hs_b}, 0);

        brd    = 3'b010;
        phase  = 0;
        iter   = 0;
        tgl    = 1'b0;
        target = 17 * FRAME_A + 700;
        while (!(phase == 3 && t_b >= FRAME_B + 16)) begin
            iter++;
            if (iter > 90000) begin
                chk("cycle_budget", iter, 90000);
                break;
            end
            if ($urandom_range(15) == 0) brd = 3'($urandom);
            case (phase)
                0: begin
                    step(1'b0, $urandom_range(3) != 0, 1'b0, 1'b1, brd);
                    if (t_a >= target) phase = 1;
                end
                1: begin
                    rst_seen = 1'b1;
                    step(1'b1, 1'b1, 1'b0, 1'b1, brd);
                    chk("mrst_rgbi", rgbi_a, 0);
                    chk("mrst_sync", {irq_a, bl_a, vs_a, hs_a}, 0);
                    cnt_on = 1'b1;
                    phase  = 2;
                end
                2: begin
                    tgl = !tgl;
                    step(1'b0, tgl, 1'b0, 1'b1, brd);
                    if (t_a >= FRAME_A) begin
                        cnt_on = 1'b0;
                        chk("irq_ce_count", irq_n, ILEN);
                        chk("hsync_ce_count", hs_n, (HS_E - HS_S + 1) * VA);
                        chk("vsync_ce_count", vs_n, (VSE_A - VSS_A + 1) * H);
                        chk("vce_count", vce_n, 64 * VA);
                        phase = 3;
                    end
                end
                default: step(1'b0, 1'($urandom_range(1)), 1'b0, 1'b1, brd);
            endcase
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
